// File: rtl/multiple_add_pipe.sv
// Fan-out add/subtract pipeline: each accepted word yields NUM_LANES results in +/- (BASE + i*STEP).
// Optional macro MULTIPLE_ADD_PIPE_DATA_RST_EN: async reset also clears data and sub registers.
module multiple_add_pipe #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_LANES  = 4,
  parameter int LATENCY    = 3,
  parameter int BASE       = 0,
  parameter int STEP       = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_in,
  output logic                  ready_out,
  input  logic                  sub_in,
  input  logic [DATA_WIDTH-1:0] in,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic [DATA_WIDTH-1:0] out [NUM_LANES]
);

  // Result stages after the lane arithmetic; LATENCY=1 folds the word stage into the result stage.
  localparam int NRES = (LATENCY == 1) ? 1 : LATENCY - 1;

  typedef logic [DATA_WIDTH-1:0] word_t;

  function automatic word_t lane_off(input int l);
    return word_t'(BASE + l * STEP);
  endfunction

  logic               en;
  logic [LATENCY-1:0] vld_q, vld_d;
  word_t              src_word;
  logic               src_sub;
  word_t              lane_d [NUM_LANES];
  word_t              res_q  [NRES][NUM_LANES];
  word_t              res_d  [NRES][NUM_LANES];

  assign valid_out = vld_q[LATENCY-1];
  assign en        = ready_in | ~valid_out;
  assign ready_out = en;

  always_comb begin
    vld_d = vld_q;
    if (en) begin
      vld_d[0] = valid_in;
      for (int s = 1; s < LATENCY; s++) vld_d[s] = vld_q[s-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_q <= '0;
    else        vld_q <= vld_d;
  end

  if (LATENCY == 1) begin : g_direct
    assign src_word = in;
    assign src_sub  = sub_in;
  end else begin : g_word
    word_t word_q, word_d;
    logic  sub_q, sub_d;

    always_comb begin
      word_d = word_q;
      sub_d  = sub_q;
      if (en) begin
        word_d = in;
        sub_d  = sub_in;
      end
    end

`ifdef MULTIPLE_ADD_PIPE_DATA_RST_EN
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        word_q <= '0;
        sub_q  <= 1'b0;
      end else begin
        word_q <= word_d;
        sub_q  <= sub_d;
      end
    end
`else
    always_ff @(posedge clk) begin
      word_q <= word_d;
      sub_q  <= sub_d;
    end
`endif

    assign src_word = word_q;
    assign src_sub  = sub_q;
  end

  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      lane_d[l] = src_sub ? (src_word - lane_off(l)) : (src_word + lane_off(l));
    end
  end

  always_comb begin
    res_d = res_q;
    if (en) begin
      res_d[0] = lane_d;
      for (int s = 1; s < NRES; s++) res_d[s] = res_q[s-1];
    end
  end

`ifdef MULTIPLE_ADD_PIPE_DATA_RST_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NRES; s++) begin
        for (int l = 0; l < NUM_LANES; l++) res_q[s][l] <= '0;
      end
    end else begin
      res_q <= res_d;
    end
  end
`else
  always_ff @(posedge clk) begin
    res_q <= res_d;
  end
`endif

  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) out[l] = res_q[NRES-1][l];
  end

endmodule

// File: tb/tb_multiple_add_pipe.sv
// Self-checking bench for multiple_add_pipe: default build plus two parameter variants on shared inputs.
module tb_multiple_add_pipe;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       vin   = 1'b0;
  logic       sub   = 1'b0;
  logic       rdy   = 1'b1;
  logic [7:0] din   = 8'h00;

  logic       ro0, vo0, roB, voB, roC, voC;
  logic [7:0] out0 [4];
  logic [7:0] outB [1];
  logic [7:0] outC [8];

  int checks   = 0;
  int failures = 0;
  logic [63:0] sb [$];

  always #5 clk = ~clk;

  multiple_add_pipe #(.DATA_WIDTH(8), .NUM_LANES(4), .LATENCY(3), .BASE(0), .STEP(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .valid_in(vin), .ready_out(ro0), .sub_in(sub), .in(din),
    .valid_out(vo0), .ready_in(rdy), .out(out0));

  multiple_add_pipe #(.DATA_WIDTH(8), .NUM_LANES(1), .LATENCY(1), .BASE(0), .STEP(1)) dutB (
    .clk(clk), .rst_n(rst_n), .valid_in(vin), .ready_out(roB), .sub_in(sub), .in(din),
    .valid_out(voB), .ready_in(rdy), .out(outB));

  multiple_add_pipe #(.DATA_WIDTH(8), .NUM_LANES(8), .LATENCY(5), .BASE(3), .STEP(7)) dutC (
    .clk(clk), .rst_n(rst_n), .valid_in(vin), .ready_out(roC), .sub_in(sub), .in(din),
    .valid_out(voC), .ready_in(rdy), .out(outC));

  function automatic logic [63:0] model(input logic [7:0] w, input logic s, input int lanes,
                                        input int base, input int step);
    logic [63:0] r;
    logic [7:0]  off;
    r = '0;
    for (int i = 0; i < lanes; i++) begin
      off = 8'(base + i * step);
      r[8*i +: 8] = s ? (w - off) : (w + off);
    end
    return r;
  endfunction

  function automatic logic [63:0] obs0();
    return {32'h0, out0[3], out0[2], out0[1], out0[0]};
  endfunction

  function automatic logic [63:0] obsC();
    return {outC[7], outC[6], outC[5], outC[4], outC[3], outC[2], outC[1], outC[0]};
  endfunction

  // Inputs change on the falling edge; outputs are observed 1ns later, well away from the rising edge.
  task automatic drive(input logic v, input logic [7:0] d, input logic s, input logic r);
    @(negedge clk);
    vin = v; din = d; sub = s; rdy = r;
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #2;
    checks++; if (vo0 !== 1'b0) begin failures++; $display("FAIL reset_valid_out0 got=%b exp=0", vo0); end
    checks++; if (ro0 !== 1'b1) begin failures++; $display("FAIL reset_ready_out0 got=%b exp=1", ro0); end
    checks++; if (voB !== 1'b0) begin failures++; $display("FAIL reset_valid_outB got=%b exp=0", voB); end
    checks++; if (voC !== 1'b0) begin failures++; $display("FAIL reset_valid_outC got=%b exp=0", voC); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_latency();
    int first = -1;
    logic [63:0] got = '0;
    drive(1'b1, 8'd10, 1'b0, 1'b1);
    checks++; if (vo0 !== 1'b0) begin failures++; $display("FAIL lat_cycle0_valid got=%b exp=0", vo0); end
    for (int k = 1; k <= 6; k++) begin
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      if (vo0 === 1'b1 && first < 0) begin first = k; got = obs0(); end
    end
    checks++; if (first != 3) begin failures++; $display("FAIL lat_first_valid got=%0d exp=3", first); end
    checks++; if (got !== 64'h0000_0000_0D0C_0B0A) begin failures++; $display("FAIL lat_value got=%h exp=%h", got, 64'h0D0C0B0A); end
  endtask

  task automatic test_wrap_sub();
    logic [63:0] got [2];
    int n = 0;
    got[0] = '0; got[1] = '0;
    for (int k = 0; k < 10; k++) begin
      if (k == 0)      drive(1'b1, 8'hFE, 1'b0, 1'b1);
      else if (k == 1) drive(1'b1, 8'h01, 1'b1, 1'b1);
      else             drive(1'b0, 8'h00, 1'b0, 1'b1);
      if (vo0 === 1'b1) begin
        if (n < 2) got[n] = obs0();
        n++;
      end
    end
    checks++; if (n != 2) begin failures++; $display("FAIL wrap_count got=%0d exp=2", n); end
    checks++; if (got[0] !== 64'h0000_0000_0100_FFFE) begin failures++; $display("FAIL wrap_add got=%h exp=0100fffe", got[0]); end
    checks++; if (got[1] !== 64'h0000_0000_FEFF_0001) begin failures++; $display("FAIL wrap_sub got=%h exp=feff0001", got[1]); end
  endtask

  task automatic test_backpressure();
    int sent = 1;
    int rcvd = 0;
    logic held = 1'b0;
    logic [63:0] hv = '0;
    logic [63:0] e;
    logic r, v;
    sb.delete();
    for (int cyc = 0; cyc < 600 && rcvd < 20; cyc++) begin
      v = (sent <= 20);
      r = 1'($urandom_range(0, 1));
      drive(v, 8'(sent), 1'b0, r);
      checks++;
      if (ro0 !== !(vo0 && !r)) begin failures++; $display("FAIL bp_ready_out got=%b exp=%b", ro0, !(vo0 && !r)); end
      if (held) begin
        checks++;
        if (vo0 !== 1'b1 || obs0() !== hv) begin
          failures++; $display("FAIL bp_stable got=%b/%h exp=1/%h", vo0, obs0(), hv);
        end
      end
      if (vo0 === 1'b1 && r) begin
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL bp_unexpected_output got=%h exp=none", obs0());
        end else begin
          e = sb.pop_front();
          if (obs0() !== e) begin failures++; $display("FAIL bp_value got=%h exp=%h", obs0(), e); end
        end
        checks++;
        if (out0[0] !== 8'(rcvd + 1)) begin failures++; $display("FAIL bp_order got=%0d exp=%0d", out0[0], rcvd + 1); end
        rcvd++;
      end
      if (v && ro0 === 1'b1) begin
        sb.push_back(model(8'(sent), 1'b0, 4, 0, 1));
        sent++;
      end
      held = (vo0 === 1'b1) && !r;
      hv = obs0();
    end
    checks++; if (rcvd != 20) begin failures++; $display("FAIL bp_received got=%0d exp=20", rcvd); end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL bp_leftover got=%0d exp=0", sb.size()); end
    for (int k = 0; k < 8; k++) drive(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_full_throughput();
    int first = -1;
    int last  = -1;
    int nval  = 0;
    int bad   = 0;
    logic [63:0] e;
    logic [7:0] d;
    logic s;
    sb.delete();
    for (int k = 0; k < 112; k++) begin
      d = 8'(k * 7);
      s = k[0];
      drive(k < 100, d, s, 1'b1);
      if (vo0 === 1'b1) begin
        if (first < 0) first = k;
        last = k;
        nval++;
        if (sb.size() == 0) bad++;
        else begin
          e = sb.pop_front();
          if (obs0() !== e) bad++;
        end
      end
      if (k < 100 && ro0 === 1'b1) sb.push_back(model(d, s, 4, 0, 1));
    end
    checks++; if (first != 3) begin failures++; $display("FAIL tput_first got=%0d exp=3", first); end
    checks++; if (nval != 100) begin failures++; $display("FAIL tput_count got=%0d exp=100", nval); end
    checks++; if (last != 102) begin failures++; $display("FAIL tput_last got=%0d exp=102", last); end
    checks++; if (bad != 0) begin failures++; $display("FAIL tput_values got=%0d_bad exp=0", bad); end
    for (int k = 0; k < 8; k++) drive(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_midreset();
    int first = -1;
    int seen = 0;
    logic [63:0] got = '0;
    drive(1'b1, 8'h40, 1'b0, 1'b1);
    drive(1'b1, 8'h41, 1'b0, 1'b1);
    drive(1'b1, 8'h42, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    checks++; if (vo0 !== 1'b1) begin failures++; $display("FAIL mr_inflight got=%b exp=1", vo0); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (vo0 !== 1'b0) begin failures++; $display("FAIL mr_valid_drop got=%b exp=0", vo0); end
    checks++; if (ro0 !== 1'b1) begin failures++; $display("FAIL mr_ready got=%b exp=1", ro0); end
`ifdef MULTIPLE_ADD_PIPE_DATA_RST_EN
    checks++; if (obs0() !== 64'h0) begin failures++; $display("FAIL mr_data_zero got=%h exp=0", obs0()); end
`endif
    #1 rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      if (vo0 !== 1'b0 || voC !== 1'b0) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL mr_ghost got=%0d exp=0", seen); end
    drive(1'b1, 8'h80, 1'b1, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      if (vo0 === 1'b1 && first < 0) begin first = k; got = obs0(); end
    end
    checks++; if (first != 3) begin failures++; $display("FAIL mr_relatency got=%0d exp=3", first); end
    checks++; if (got !== 64'h0000_0000_7D7E_7F80) begin failures++; $display("FAIL mr_value got=%h exp=7d7e7f80", got); end
  endtask

  task automatic test_params();
    logic [7:0] tw [3];
    logic       ts [3];
    logic [7:0] t7 [3];
    int fB, fC;
    logic [63:0] gB, gC;
    tw[0] = 8'h20; ts[0] = 1'b0; t7[0] = 8'h54;
    tw[1] = 8'h05; ts[1] = 1'b1; t7[1] = 8'hD1;
    tw[2] = 8'hF0; ts[2] = 1'b0; t7[2] = 8'h24;
    for (int k = 0; k < 8; k++) drive(1'b0, 8'h00, 1'b0, 1'b1);
    for (int t = 0; t < 3; t++) begin
      fB = -1; fC = -1; gB = '0; gC = '0;
      drive(1'b1, tw[t], ts[t], 1'b1);
      for (int k = 1; k <= 8; k++) begin
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        if (voB === 1'b1 && fB < 0) begin fB = k; gB = {56'h0, outB[0]}; end
        if (voC === 1'b1 && fC < 0) begin fC = k; gC = obsC(); end
      end
      checks++; if (fB != 1) begin failures++; $display("FAIL pB_latency t=%0d got=%0d exp=1", t, fB); end
      checks++; if (gB !== model(tw[t], ts[t], 1, 0, 1)) begin failures++; $display("FAIL pB_value t=%0d got=%h exp=%h", t, gB, model(tw[t], ts[t], 1, 0, 1)); end
      checks++; if (fC != 5) begin failures++; $display("FAIL pC_latency t=%0d got=%0d exp=5", t, fC); end
      checks++; if (gC !== model(tw[t], ts[t], 8, 3, 7)) begin failures++; $display("FAIL pC_value t=%0d got=%h exp=%h", t, gC, model(tw[t], ts[t], 8, 3, 7)); end
      checks++; if (gC[63:56] !== t7[t]) begin failures++; $display("FAIL pC_lane7 t=%0d got=%h exp=%h", t, gC[63:56], t7[t]); end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_wrap_sub();
    test_backpressure();
    test_full_throughput();
    test_midreset();
    test_params();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
